pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and branch-resolution stage directly upstream of CPU_control in the single-cycle 16-bit core.
- Holds the PC register and the Z/V/N flag register, and computes next-PC from the CPU_control outputs halt/BEn/Br.
- Drives the instruction-memory address; instr[15:12] of the fetched word feeds CPU_control.opc.
- Exports PC+2 for the PCS write-back path and a sticky halted status to the top level.

Parameters:
- PC_WIDTH, 16, width of PC and all address/data operands.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and flags this cycle (future hazard hook; tie 0 in single-cycle top).
- halt  in  1  from CPU_control; HLT decoded.
- BEn  in  1  from CPU_control; branch instruction (B or BR).
- Br  in  1  from CPU_control; 1 = register target (BR), 0 = PC-relative (B).
- cond  in  3  instr[11:9], branch condition code.
- imm9  in  9  instr[8:0], signed word offset for B.
- rs_data  in  PC_WIDTH  register-file read data, target for BR.
- alu_z, alu_v, alu_n  in  1 each  ALU flag results of the current instruction.
- flag_we_z  in  1  write Z (ADD, SUB, XOR, SLL, SRA, ROR).
- flag_we_vn  in  1  write V and N (ADD, SUB only).
- pc  out  PC_WIDTH  current PC / imem address.
- pc_plus2  out  PC_WIDTH  pc + 2, mod 2^16.
- br_taken  out  1  combinational; branch resolves taken this cycle.
- flags  out  3  {Z,V,N} registered.
- halted  out  1  sticky halt status.

Behaviour:
- Reset (async, on rst high): pc=RESET_PC, flags=3'b000, halted=0. Outputs hold these values while rst is high. Release is synchronous to the next rising clk.
- Condition evaluation uses registered flags only, i.e. flags written by earlier instructions:
  - 000 NEQ Z==0; 001 EQ Z==1; 010 GT Z==0&&N==0; 011 LT N==1.
  - 100 GTE Z==1||N==0; 101 LTE N==1||Z==1; 110 OVFL V==1; 111 unconditional.
- br_taken = BEn & cond_true & ~halted.
- Next-PC priority at each rising edge:
  1. halted or halt: pc holds and halted is set to 1. HLT itself never advances PC.
  2. stall: pc holds.
  3. br_taken & Br: pc = rs_data.
  4. br_taken & ~Br: pc = pc_plus2 + (sign_extend(imm9) << 1).
  5. otherwise: pc = pc_plus2.
- Arithmetic is modulo 2^PC_WIDTH. 16'hFFFE + 2 wraps to 0. Branch targets wrap silently, with no fault.
- BR with an odd rs_data loads the value unmodified; alignment is software's responsibility.
- Flag update at the rising edge when ~stall & ~halted:
  - Z <= alu_z if flag_we_z.
  - V,N <= alu_v, alu_n if flag_we_vn.
  - Unwritten flags hold.
- A branch and a flag write in the same cycle cannot occur (decoder guarantees). If both are forced, the branch uses the old flags and the write takes effect for the next instruction.
- Once halted=1, pc, flags and halted are frozen until rst. Inputs are ignored.
- rst asserted mid-halt or mid-stall returns the block to the reset state immediately.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- Defined: adds outputs instr_cnt[15:0] and taken_cnt[15:0], reset to 0.
  - instr_cnt increments on each edge where ~stall & ~halted. The HLT cycle counts once.
  - taken_cnt increments on each edge where br_taken & ~stall.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package cpu_pkg:
  - Condition-code localparams: CC_NEQ..CC_UNCOND.
  - Flag bit indices: FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - Opcode constants shared with CPU_control.
- One combinational sub-module, branch_cond_eval: (cond, flags) -> cond_true. Reused later by the pipelined branch-resolution stage.

Test Plan:
1. Reset then 4 sequential cycles -> pc = 0, 2, 4, 6, 8. Assert rst mid-run at pc=6 -> pc=0 immediately, without waiting for clk.
2. Flags Z=1 via flag_we_z, next cycle BEn=1, Br=0, cond=001, imm9=9'h1FE (-2) at pc=0x0010 -> br_taken=1, pc=0x000E. With cond=000, same setup -> pc=0x0012.
3. BEn=1, Br=1, cond=111, rs_data=0x1234 -> pc=0x1234 next edge. With Br=1, cond=110 and V=0 -> pc+2.
4. flag_we_vn only with alu_z=1, alu_v=1, alu_n=1 from flags=000 -> flags=3'b011. Then LT branch is taken and EQ branch is not taken.
5. halt=1 at pc=0x0020 -> halted=1, pc stays 0x0020 for 10 cycles while BEn and flag writes toggle. rst then clears halted.
6. pc=0xFFFE, no branch -> pc=0x0000. stall=1 for 3 cycles with flag_we_z=1 -> pc and flags unchanged. With PC_PERF_CNT_EN, instr_cnt does not advance during the stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit core: branch condition codes, flag bit
// positions, opcode encodings and the fetch-stage run/halt state.
package cpu_pkg;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_SUB  = 4'h1,
    OPC_XOR  = 4'h2,
    OPC_SLL  = 4'h3,
    OPC_SRA  = 4'h4,
    OPC_ROR  = 4'h5,
    OPC_PADD = 4'h6,
    OPC_RED  = 4'h7,
    OPC_LW   = 4'h8,
    OPC_SW   = 4'h9,
    OPC_LLB  = 4'hA,
    OPC_LHB  = 4'hB,
    OPC_B    = 4'hC,
    OPC_BR   = 4'hD,
    OPC_PCS  = 4'hE,
    OPC_HLT  = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition code against registered {Z,V,N} flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_NEQ:    cond_true = ~z;
      CC_EQ:     cond_true = z;
      CC_GT:     cond_true = ~z & ~n;
      CC_LT:     cond_true = n;
      CC_GTE:    cond_true = z | ~n;
      CC_LTE:    cond_true = n | z;
      CC_OVFL:   cond_true = v;
      CC_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, flag register and next-PC/branch resolution for the 16-bit core.
// Optional performance counters are enabled by defining PC_PERF_CNT_EN.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned             PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt,
  input  logic                BEn,
  input  logic                Br,
  input  logic [2:0]          cond,
  input  logic [8:0]          imm9,
  input  logic [PC_WIDTH-1:0] rs_data,
  input  logic                alu_z,
  input  logic                alu_v,
  input  logic                alu_n,
  input  logic                flag_we_z,
  input  logic                flag_we_vn,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus2,
  output logic                br_taken,
  output logic [2:0]          flags,
  output logic                halted
`ifdef PC_PERF_CNT_EN
  ,
  output logic [15:0]         instr_cnt,
  output logic [15:0]         taken_cnt
`endif
);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [2:0]          flags_q;
  logic [2:0]          flags_d;
  logic [PC_WIDTH-1:0] br_offset;
  logic                cond_true;

  branch_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign halted   = (state_q == ST_HALTED);
  assign pc       = pc_q;
  assign flags    = flags_q;
  assign pc_plus2 = pc_q + PC_WIDTH'(2);
  assign br_taken = BEn & cond_true & ~halted;

  // Word offset: sign-extend imm9 and scale by two in one concatenation.
  assign br_offset = {{(PC_WIDTH-10){imm9[8]}}, imm9, 1'b0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;

    if (halted || halt) begin
      state_d = ST_HALTED;
    end else if (!stall) begin
      if (br_taken && Br)
        pc_d = rs_data;
      else if (br_taken)
        pc_d = pc_plus2 + br_offset;
      else
        pc_d = pc_plus2;
    end

    // Flags written here are only seen by the branch of a later instruction.
    if (!stall && !halted) begin
      if (flag_we_z)
        flags_d[FLAG_Z] = alu_z;
      if (flag_we_vn) begin
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_N] = alu_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

`ifdef PC_PERF_CNT_EN
  logic instr_inc;
  logic taken_inc;

  assign instr_inc = ~stall & ~halted;
  assign taken_inc = br_taken & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (instr_inc && (instr_cnt != '1))
        instr_cnt <= instr_cnt + 16'd1;
      if (taken_inc && (taken_cnt != '1))
        taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (counter checks when PC_PERF_CNT_EN is defined).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        BEn = 1'b0;
  logic        Br = 1'b0;
  logic [2:0]  cond = 3'b000;
  logic [8:0]  imm9 = 9'h000;
  logic [15:0] rs_data = 16'h0000;
  logic        alu_z = 1'b0;
  logic        alu_v = 1'b0;
  logic        alu_n = 1'b0;
  logic        flag_we_z = 1'b0;
  logic        flag_we_vn = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        br_taken;
  logic [2:0]  flags;
  logic        halted;
`ifdef PC_PERF_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] taken_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt       (halt),
    .BEn        (BEn),
    .Br         (Br),
    .cond       (cond),
    .imm9       (imm9),
    .rs_data    (rs_data),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .flag_we_z  (flag_we_z),
    .flag_we_vn (flag_we_vn),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .br_taken   (br_taken),
    .flags      (flags),
    .halted     (halted)
`ifdef PC_PERF_CNT_EN
    ,
    .instr_cnt  (instr_cnt),
    .taken_cnt  (taken_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; halt = 1'b0; BEn = 1'b0; Br = 1'b0;
    cond = 3'b000; imm9 = 9'h000; rs_data = 16'h0000;
    alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    flag_we_z = 1'b0; flag_we_vn = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reset, step seven plain cycles to 0x000E, then write Z=1 on the way to 0x0010.
  task automatic goto_0x10_with_z();
    do_reset();
    for (int unsigned i = 0; i < 7; i++) tick();
    flag_we_z = 1'b1; alu_z = 1'b1;
    tick();
    flag_we_z = 1'b0; alu_z = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0000); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected %b", flags, 3'b000); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected %b", halted, 1'b0); end
    checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL reset_pc_plus2: got %h expected %h", pc_plus2, 16'h0002); end
`ifdef PC_PERF_CNT_EN
    checks++; if (instr_cnt !== 16'h0000) begin errors++; $display("FAIL reset_instr_cnt: got %h expected %h", instr_cnt, 16'h0000); end
    checks++; if (taken_cnt !== 16'h0000) begin errors++; $display("FAIL reset_taken_cnt: got %h expected %h", taken_cnt, 16'h0000); end
`endif
    tick();
    rst = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== 16'(2 * i)) begin errors++; $display("FAIL seq_pc_%0d: got %h expected %h", i, pc, 16'(2 * i)); end
    end
    do_reset();
    for (int unsigned i = 0; i < 3; i++) tick();
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL pre_async_pc: got %h expected %h", pc, 16'h0006); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, 16'h0000); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_branch_rel();
    goto_0x10_with_z();
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL rel_setup_pc: got %h expected %h", pc, 16'h0010); end
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL rel_setup_flags: got %b expected %b", flags, 3'b100); end
    BEn = 1'b1; Br = 1'b0; cond = 3'b001; imm9 = 9'h1FE;
    #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL rel_eq_taken: got %b expected %b", br_taken, 1'b1); end
    tick();
    checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL rel_eq_pc: got %h expected %h", pc, 16'h000E); end
    goto_0x10_with_z();
    BEn = 1'b1; Br = 1'b0; cond = 3'b000; imm9 = 9'h1FE;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL rel_neq_taken: got %b expected %b", br_taken, 1'b0); end
    tick();
    checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL rel_neq_pc: got %h expected %h", pc, 16'h0012); end
    // Forward offset +5 words from 0x0012: 0x0014 + 0x000A.
    cond = 3'b111; imm9 = 9'h005;
    tick();
    checks++; if (pc !== 16'h001E) begin errors++; $display("FAIL rel_fwd_pc: got %h expected %h", pc, 16'h001E); end
    BEn = 1'b0;
  endtask

  task automatic test_branch_reg();
    do_reset();
    BEn = 1'b1; Br = 1'b1; cond = 3'b111; rs_data = 16'h1234;
    #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL reg_uncond_taken: got %b expected %b", br_taken, 1'b1); end
    tick();
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL reg_uncond_pc: got %h expected %h", pc, 16'h1234); end
    cond = 3'b110; rs_data = 16'h4000;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reg_ovfl_taken: got %b expected %b", br_taken, 1'b0); end
    tick();
    checks++; if (pc !== 16'h1236) begin errors++; $display("FAIL reg_ovfl_pc: got %h expected %h", pc, 16'h1236); end
    cond = 3'b111; rs_data = 16'h0101;
    tick();
    checks++; if (pc !== 16'h0101) begin errors++; $display("FAIL reg_odd_pc: got %h expected %h", pc, 16'h0101); end
    BEn = 1'b0;
  endtask

  task automatic test_flags_vn();
    do_reset();
    flag_we_vn = 1'b1; alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    tick();
    flag_we_vn = 1'b0; alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    checks++; if (flags !== 3'b011) begin errors++; $display("FAIL vn_flags: got %b expected %b", flags, 3'b011); end
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL vn_pc: got %h expected %h", pc, 16'h0002); end
    BEn = 1'b1; Br = 1'b0; cond = 3'b011; imm9 = 9'h004;
    #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL vn_lt_taken: got %b expected %b", br_taken, 1'b1); end
    tick();
    checks++; if (pc !== 16'h000C) begin errors++; $display("FAIL vn_lt_pc: got %h expected %h", pc, 16'h000C); end
    cond = 3'b001;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL vn_eq_taken: got %b expected %b", br_taken, 1'b0); end
    tick();
    checks++; if (pc !== 16'h000E) begin errors++; $display("FAIL vn_eq_pc: got %h expected %h", pc, 16'h000E); end
    cond = 3'b010; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL vn_gt_taken: got %b expected %b", br_taken, 1'b0); end
    cond = 3'b101; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL vn_lte_taken: got %b expected %b", br_taken, 1'b1); end
    cond = 3'b110; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL vn_ovfl_taken: got %b expected %b", br_taken, 1'b1); end
    // Forced branch + Z write: EQ sees old Z=0, write lands afterwards.
    cond = 3'b001; flag_we_z = 1'b1; alu_z = 1'b1;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL vn_same_cycle_taken: got %b expected %b", br_taken, 1'b0); end
    tick();
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL vn_same_cycle_pc: got %h expected %h", pc, 16'h0010); end
    checks++; if (flags !== 3'b111) begin errors++; $display("FAIL vn_same_cycle_flags: got %b expected %b", flags, 3'b111); end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    for (int unsigned i = 0; i < 16; i++) tick();
    checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL halt_setup_pc: got %h expected %h", pc, 16'h0020); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected %b", halted, 1'b1); end
    checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL halt_pc: got %h expected %h", pc, 16'h0020); end
    for (int unsigned i = 0; i < 10; i++) begin
      BEn = i[0]; Br = 1'b1; cond = 3'b111; rs_data = 16'h5555;
      flag_we_z = ~i[0]; flag_we_vn = i[1]; alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
      #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL halt_br_taken_%0d: got %b expected %b", i, br_taken, 1'b0); end
      tick();
      checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL halt_hold_pc_%0d: got %h expected %h", i, pc, 16'h0020); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL halt_hold_flags_%0d: got %b expected %b", i, flags, 3'b000); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold_halted_%0d: got %b expected %b", i, halted, 1'b1); end
    end
`ifdef PC_PERF_CNT_EN
    checks++; if (instr_cnt !== 16'd17) begin errors++; $display("FAIL halt_instr_cnt: got %0d expected %0d", instr_cnt, 17); end
    checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL halt_taken_cnt: got %0d expected %0d", taken_cnt, 0); end
`endif
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted: got %b expected %b", halted, 1'b0); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL halt_rst_pc: got %h expected %h", pc, 16'h0000); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap_stall();
    do_reset();
    BEn = 1'b1; Br = 1'b1; cond = 3'b111; rs_data = 16'hFFFE;
    tick();
    clear_inputs();
    checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_setup_pc: got %h expected %h", pc, 16'hFFFE); end
    checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus2: got %h expected %h", pc_plus2, 16'h0000); end
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 16'h0000); end
    stall = 1'b1; flag_we_z = 1'b1; alu_z = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL stall_pc_%0d: got %h expected %h", i, pc, 16'h0000); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL stall_flags_%0d: got %b expected %b", i, flags, 3'b000); end
    end
`ifdef PC_PERF_CNT_EN
    checks++; if (instr_cnt !== 16'd2) begin errors++; $display("FAIL stall_instr_cnt: got %0d expected %0d", instr_cnt, 2); end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL stall_taken_cnt: got %0d expected %0d", taken_cnt, 1); end
`endif
    stall = 1'b0;
    tick();
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL post_stall_pc: got %h expected %h", pc, 16'h0002); end
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL post_stall_flags: got %b expected %b", flags, 3'b100); end
    // Backward branch across zero wraps silently: 0x0004 + (-4 words) = 0xFFFC.
    clear_inputs();
    BEn = 1'b1; Br = 1'b0; cond = 3'b111; imm9 = 9'h1FC;
    tick();
    checks++; if (pc !== 16'hFFFC) begin errors++; $display("FAIL wrap_branch_pc: got %h expected %h", pc, 16'hFFFC); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch_rel();
    test_branch_reg();
    test_flags_vn();
    test_halt();
    test_wrap_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
